// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game-of-Life command sequencer.
//   CMD_NOP / CMD_STEP / CMD_WRITE : encodings of the 2-bit pe_array command
//   ctrl_state_t                   : sequencer FSM state
// ---------------------------------------------------------------------------
package life_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBL,
        STEP,
        WRITE,
        GUARD
    } ctrl_state_t;

endpackage

// File: rtl/life_ctrl_btn_cond.sv
// ---------------------------------------------------------------------------
// btn_cond
// Conditions one raw board button into a single-cycle request pulse:
// 2-FF synchroniser, optional debouncer, rising-edge detect.
// Optional feature macro: LIFE_CTRL_DEBOUNCE_EN (enables the debouncer).
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   btn    in  raw asynchronous button level
//   pulse  out one-cycle pulse per rising edge, 3 cycles after the raw edge
//              (plus DEBOUNCE_CYCLES when the debouncer is enabled)
// ---------------------------------------------------------------------------
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_prev;

    // Two-stage synchroniser for the asynchronous button input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef LIFE_CTRL_DEBOUNCE_EN
    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_BITS-1:0] stable_cnt;

    // A new level is accepted only once it has persisted for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    // Registered rising-edge detect: holding the button never repeats
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            level_prev <= level;
            pulse      <= level & ~level_prev;
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
// Command sequencer for the PE array. Turns step/run/write buttons into
// single-cycle cmd pulses, aligns generation steps to the start of vertical
// blanking, offers a free-running run mode and counts generations.
// Optional feature macro: LIFE_CTRL_DEBOUNCE_EN (button debouncers).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   step_btn, run_btn,
//   write_btn             raw board buttons
//   wr_x, wr_y, wr_val    write address/data from switches
//   vblank                vertical blanking level from the VGA driver
//   cmd                   pe_array command (00 NOP, 01 STEP, 11 WRITE)
//   adr_x, adr_y,
//   state_wr              captured write address/data to the array
//   busy                  FSM not IDLE
//   running               run mode active
//   gen_count             generations issued
// ---------------------------------------------------------------------------
module life_ctrl
    import life_pkg::*;
#(
    parameter int X_BITS          = 4,
    parameter int Y_BITS          = 4,
    parameter int GEN_FRAMES      = 30,
    parameter int GUARD_CYCLES    = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GEN_BITS        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_btn,
    input  logic                run_btn,
    input  logic                write_btn,
    input  logic [X_BITS-1:0]   wr_x,
    input  logic [Y_BITS-1:0]   wr_y,
    input  logic                wr_val,
    input  logic                vblank,
    output logic [1:0]          cmd,
    output logic [X_BITS-1:0]   adr_x,
    output logic [Y_BITS-1:0]   adr_y,
    output logic                state_wr,
    output logic                busy,
    output logic                running,
    output logic [GEN_BITS-1:0] gen_count
);

    localparam int FC_BITS = 16;

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic               step_req;
    logic               run_req;
    logic               write_req;
    logic               vbl_d1;
    logic               vbl_d2;
    logic               vbl_rise;
    logic [FC_BITS-1:0] frame_cnt;
    logic [FC_BITS-1:0] frame_next;
    logic               frame_tick;
    logic               step_pend;
    logic               wr_pend;
    logic [7:0]         guard_cnt;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_cond (
        .clk(clk), .reset(reset), .btn(step_btn), .pulse(step_req)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_cond (
        .clk(clk), .reset(reset), .btn(run_btn), .pulse(run_req)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_write_cond (
        .clk(clk), .reset(reset), .btn(write_btn), .pulse(write_req)
    );

    // vblank edge is seen one cycle after it rises
    assign vbl_rise = vbl_d1 & ~vbl_d2;

    // Frame counter cycles 0..GEN_FRAMES-1; the tick fires on the edge that
    // moves it onto GEN_FRAMES-1, so ticks come exactly GEN_FRAMES frames apart
    always_comb begin
        frame_next = (frame_cnt == FC_BITS'(GEN_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
        frame_tick = running & vbl_rise & (frame_next == FC_BITS'(GEN_FRAMES - 1));
    end

    // Request capture: a new request wins over the clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            vbl_d1    <= 1'b0;
            vbl_d2    <= 1'b0;
            running   <= 1'b0;
            frame_cnt <= '0;
            step_pend <= 1'b0;
            wr_pend   <= 1'b0;
            adr_x     <= '0;
            adr_y     <= '0;
            state_wr  <= 1'b0;
        end else begin
            vbl_d1 <= vblank;
            vbl_d2 <= vbl_d1;

            if (run_req) begin
                running <= ~running;
            end

            if (run_req && running) begin
                frame_cnt <= '0;
            end else if (running && vbl_rise) begin
                frame_cnt <= frame_next;
            end

            if (step_req || frame_tick) begin
                step_pend <= 1'b1;
            end else if (state == STEP) begin
                step_pend <= 1'b0;
            end

            if (write_req) begin
                wr_pend  <= 1'b1;
                adr_x    <= wr_x;
                adr_y    <= wr_y;
                state_wr <= wr_val;
            end else if (state == WRITE) begin
                wr_pend <= 1'b0;
            end
        end
    end

    // FSM state register, guard timer, registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            guard_cnt <= '0;
            busy      <= 1'b0;
            gen_count <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            guard_cnt <= (state == GUARD) ? guard_cnt + 1'b1 : 8'd0;
            if (state == STEP) begin
                gen_count <= gen_count + 1'b1;
            end
        end
    end

    // Next-state and command decode; write requests always take priority
    always_comb begin
        state_next = state;
        cmd        = CMD_NOP;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    state_next = WRITE;
                end else if (step_pend) begin
                    state_next = WAIT_VBL;
                end
            end
            WAIT_VBL: begin
                if (wr_pend) begin
                    state_next = WRITE;
                end else if (vbl_rise) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                cmd        = CMD_STEP;
                state_next = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            end
            WRITE: begin
                cmd        = CMD_WRITE;
                state_next = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            end
            GUARD: begin
                if (guard_cnt == 8'(GUARD_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_life_ctrl
// Directed bench for life_ctrl with GEN_FRAMES=3, GUARD_CYCLES=2.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// Cycle counts below are measured from the edge after which a stimulus is
// applied: a button reaches the FSM as a pending flag 4 edges later and the
// command appears on edge 5; a vblank rise gives STEP 2 edges later.
// ---------------------------------------------------------------------------
module tb_life_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_btn;
    logic       run_btn;
    logic       write_btn;
    logic [3:0] wr_x;
    logic [3:0] wr_y;
    logic       wr_val;
    logic       vblank;
    logic [1:0] cmd;
    logic [3:0] adr_x;
    logic [3:0] adr_y;
    logic       state_wr;
    logic       busy;
    logic       running;
    logic [15:0] gen_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    life_ctrl #(
        .X_BITS(4), .Y_BITS(4), .GEN_FRAMES(3), .GUARD_CYCLES(2),
        .DEBOUNCE_CYCLES(4), .GEN_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .step_btn(step_btn), .run_btn(run_btn),
        .write_btn(write_btn), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
        .vblank(vblank), .cmd(cmd), .adr_x(adr_x), .adr_y(adr_y),
        .state_wr(state_wr), .busy(busy), .running(running), .gen_count(gen_count)
    );

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for a few cycles with all buttons released
    task automatic do_reset();
        reset     = 1'b1;
        step_btn  = 1'b0;
        run_btn   = 1'b0;
        write_btn = 1'b0;
        vblank    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Single press of run_btn, then wait until the toggle has landed
    task automatic press_run();
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        repeat (5) tick();
    endtask

    // Raise vblank and count STEP cycles over the following 10 edges
    task automatic vblank_burst(output int n_step, output int step_at);
        n_step  = 0;
        step_at = -1;
        vblank  = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 5) vblank = 1'b0;
            if (cmd == 2'b01) begin
                n_step++;
                step_at = j;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_checks++; if (cmd !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_cmd: got %0b expected 00", cmd); end
        n_checks++; if (adr_x !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_adr_x: got %0d expected 0", adr_x); end
        n_checks++; if (adr_y !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_adr_y: got %0d expected 0", adr_y); end
        n_checks++; if (state_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_state_wr: got %0b expected 0", state_wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_running: got %0b expected 0", running); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_gen_count: got %0d expected 0", gen_count); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmd !== 2'b00 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", bad); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("[TB] FAIL idle_gen_count: got %0d expected 0", gen_count); end
    endtask

    task automatic test_write();
        int n_wr, wr_at, n_st;
        logic [3:0] ax, ay;
        logic sw, busy7, busy8;
        do_reset();
        n_wr = 0; wr_at = -1; n_st = 0;
        ax = '0; ay = '0; sw = 1'b0; busy7 = 1'b0; busy8 = 1'b1;
        wr_x = 4'd5; wr_y = 4'd9; wr_val = 1'b1;
        write_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 4) write_btn = 1'b0;
            if (cmd == 2'b11) begin
                n_wr++;
                wr_at = i;
                ax = adr_x; ay = adr_y; sw = state_wr;
            end
            if (cmd == 2'b01) n_st++;
            if (i == 7) busy7 = busy;
            if (i == 8) busy8 = busy;
        end
        n_checks++; if (n_wr != 1) begin n_fail++; $display("[TB] FAIL write_count: got %0d expected 1", n_wr); end
        n_checks++; if (wr_at != 5) begin n_fail++; $display("[TB] FAIL write_latency: got cycle %0d expected 5", wr_at); end
        n_checks++; if (ax !== 4'd5) begin n_fail++; $display("[TB] FAIL write_adr_x: got %0d expected 5", ax); end
        n_checks++; if (ay !== 4'd9) begin n_fail++; $display("[TB] FAIL write_adr_y: got %0d expected 9", ay); end
        n_checks++; if (sw !== 1'b1) begin n_fail++; $display("[TB] FAIL write_state_wr: got %0b expected 1", sw); end
        n_checks++; if (n_st != 0) begin n_fail++; $display("[TB] FAIL write_no_step: got %0d expected 0", n_st); end
        n_checks++; if (busy7 !== 1'b1) begin n_fail++; $display("[TB] FAIL write_guard_busy: got %0b expected 1", busy7); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("[TB] FAIL write_guard_end: got %0b expected 0", busy8); end
        wr_x = 4'd0; wr_y = 4'd0; wr_val = 1'b0;
        tick();
        n_checks++; if (adr_x !== 4'd5) begin n_fail++; $display("[TB] FAIL write_capture_hold: got %0d expected 5", adr_x); end
    endtask

    task automatic test_step();
        int n_cmd, n_st, st_at;
        logic [15:0] g2, g3;
        do_reset();
        n_cmd = 0; g2 = '1; g3 = '0;
        step_btn = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            tick();
            if (i == 2) step_btn = 1'b0;
            if (cmd != 2'b00) n_cmd++;
        end
        n_checks++; if (n_cmd != 0) begin n_fail++; $display("[TB] FAIL step_wait_vbl: got %0d commands expected 0", n_cmd); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL step_wait_busy: got %0b expected 1", busy); end
        n_st = 0; st_at = -1;
        vblank = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (cmd == 2'b01) begin
                n_st++;
                st_at = j;
            end
            if (j == 2) g2 = gen_count;
            if (j == 3) g3 = gen_count;
        end
        vblank = 1'b0;
        tick();
        n_checks++; if (n_st != 1) begin n_fail++; $display("[TB] FAIL step_count: got %0d expected 1", n_st); end
        n_checks++; if (st_at != 2) begin n_fail++; $display("[TB] FAIL step_latency: got cycle %0d expected 2", st_at); end
        n_checks++; if (g2 !== 16'd0) begin n_fail++; $display("[TB] FAIL step_gen_during: got %0d expected 0", g2); end
        n_checks++; if (g3 !== 16'd1) begin n_fail++; $display("[TB] FAIL step_gen_after: got %0d expected 1", g3); end
    endtask

    task automatic test_back_to_back();
        int n_wr, wr_at, n_st, st_at;
        do_reset();
        n_wr = 0; wr_at = -1; n_st = 0;
        wr_x = 4'd3; wr_y = 4'd12; wr_val = 1'b0;
        step_btn  = 1'b1;
        write_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 2) begin
                step_btn  = 1'b0;
                write_btn = 1'b0;
            end
            if (cmd == 2'b11) begin
                n_wr++;
                wr_at = i;
            end
            if (cmd == 2'b01) n_st++;
        end
        n_checks++; if (wr_at != 5 || n_wr != 1) begin n_fail++; $display("[TB] FAIL b2b_write_first: got %0d writes at cycle %0d expected 1 at 5", n_wr, wr_at); end
        n_checks++; if (n_st != 0) begin n_fail++; $display("[TB] FAIL b2b_step_held: got %0d steps expected 0", n_st); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_step_pending: got busy %0b expected 1", busy); end
        n_checks++; if (adr_y !== 4'd12) begin n_fail++; $display("[TB] FAIL b2b_adr_y: got %0d expected 12", adr_y); end
        vblank_burst(n_st, st_at);
        n_checks++; if (n_st != 1 || st_at != 2) begin n_fail++; $display("[TB] FAIL b2b_step: got %0d steps at cycle %0d expected 1 at 2", n_st, st_at); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("[TB] FAIL b2b_gen_count: got %0d expected 1", gen_count); end
    endtask

    task automatic test_run_mode();
        int n_st, total;
        do_reset();
        press_run();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("[TB] FAIL run_on: got %0b expected 1", running); end
        // Frames of 20 cycles; with GEN_FRAMES=3 steps land in frames 3, 6, 9
        for (int f = 1; f <= 9; f++) begin
            n_st   = 0;
            vblank = 1'b1;
            for (int j = 1; j <= 20; j++) begin
                tick();
                if (j == 5) vblank = 1'b0;
                if (cmd == 2'b01) n_st++;
            end
            n_checks++;
            if (n_st != ((f % 3 == 0) ? 1 : 0)) begin
                n_fail++;
                $display("[TB] FAIL run_frame_%0d: got %0d steps expected %0d", f, n_st, (f % 3 == 0) ? 1 : 0);
            end
        end
        n_checks++; if (gen_count !== 16'd3) begin n_fail++; $display("[TB] FAIL run_gen_count: got %0d expected 3", gen_count); end
        press_run();
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("[TB] FAIL run_off: got %0b expected 0", running); end
        total = 0;
        for (int f = 1; f <= 6; f++) begin
            vblank = 1'b1;
            for (int j = 1; j <= 20; j++) begin
                tick();
                if (j == 5) vblank = 1'b0;
                if (cmd == 2'b01) total++;
            end
        end
        n_checks++; if (total != 0) begin n_fail++; $display("[TB] FAIL run_stopped: got %0d steps expected 0", total); end
        n_checks++; if (gen_count !== 16'd3) begin n_fail++; $display("[TB] FAIL run_gen_frozen: got %0d expected 3", gen_count); end
    endtask

    task automatic test_reset_mid();
        int n_st, st_at;
        do_reset();
        press_run();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        repeat (6) tick();
        n_checks++; if (busy !== 1'b1 || running !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_setup: got busy %0b running %0b expected 1 1", busy, running); end
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_running: got %0b expected 0", running); end
        reset = 1'b0;
        vblank_burst(n_st, st_at);
        n_checks++; if (n_st != 0) begin n_fail++; $display("[TB] FAIL mid_no_step: got %0d steps at cycle %0d expected 0", n_st, st_at); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_gen_count: got %0d expected 0", gen_count); end
    endtask

    initial begin
        reset     = 1'b1;
        step_btn  = 1'b0;
        run_btn   = 1'b0;
        write_btn = 1'b0;
        wr_x      = 4'd0;
        wr_y      = 4'd0;
        wr_val    = 1'b0;
        vblank    = 1'b0;
        $display("[TB] life_ctrl directed test start");
        test_reset();
        test_write();
        test_step();
        test_back_to_back();
        test_run_mode();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
